// File: rtl/burst_slot_ring_pkg.sv
// ---------------------------------------------------------------------------
// burst_slot_ring_pkg
// Shared constants and helpers for the burst slot ring.
// awuser encodings are kept identical to the fixed 6-slot store so downstream
// box_master decoding does not change.
// ---------------------------------------------------------------------------
package burst_slot_ring_pkg;

    // awuser classes carried with every burst
    localparam logic [1:0] REGULAR = 2'b00;
    localparam logic [1:0] BLOCK   = 2'b01;
    localparam logic [1:0] DIVERT  = 2'b10;
    localparam logic [1:0] UNLUCKY = 2'b11;

    // Bit offset of beat 'beat' inside the flattened burst data bus
    // (beat 0 occupies the least significant bits).
    function automatic int unsigned beat_offset(input int unsigned beat,
                                                input int unsigned data_bytes);
        return beat * 8 * data_bytes;
    endfunction

endpackage : burst_slot_ring_pkg

// File: rtl/burst_slot_ring_ring_ptr.sv
// ---------------------------------------------------------------------------
// ring_ptr
// Modulo-DEPTH pointer: advances by one on 'inc' and wraps from DEPTH-1 to 0.
// DEPTH need not be a power of two.
// ---------------------------------------------------------------------------
module ring_ptr #(
    parameter int DEPTH = 6
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int W = $clog2(DEPTH);

    // Pointer register with explicit wrap at the last slot
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule : ring_ptr

// File: rtl/burst_slot_ring.sv
// ---------------------------------------------------------------------------
// burst_slot_ring
// Collects AXI3 write bursts (AW header + all W beats) into a circular ring
// of SLOT_AMOUNT slots and presents each completed burst, in arrival order,
// on a single valid/ready output channel towards box_master.
//
// Pointers:
//   tail - next slot to receive an AW header
//   fill - slot currently receiving W beats
//   head - next slot to hand out
//
// A per-ID cancel marks held bursts UNLUCKY; they are still filled and output.
//
// Build option:
//   BURST_SLOT_RING_WLAST_CHECK_EN - when defined, err_wlast flags (sticky)
//   any accepted beat whose wlast disagrees with awlen. Without it wlast is
//   ignored and err_wlast is tied low. Completion always follows awlen.
// ---------------------------------------------------------------------------
module burst_slot_ring
    import burst_slot_ring_pkg::*;
#(
    parameter int SLOT_AMOUNT = 6,
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 3,
    parameter int DATA_BYTES  = 16,
    parameter int USER_WIDTH  = 2,
    parameter int IDX_W       = $clog2(SLOT_AMOUNT)
) (
    input  logic                                         clk,
    input  logic                                         resetn,

    input  logic                                         awvalid,
    output logic                                         awready,
    input  logic [ID_WIDTH-1:0]                          awid,
    input  logic [LEN_WIDTH-1:0]                         awlen,
    input  logic [ADDR_WIDTH-1:0]                        awaddr,
    input  logic [2:0]                                   awsize,
    input  logic [1:0]                                   awburst,
    input  logic [USER_WIDTH-1:0]                        awuser,

    input  logic                                         wvalid,
    output logic                                         wready,
    input  logic [8*DATA_BYTES-1:0]                      wdata,
    input  logic [DATA_BYTES-1:0]                        wstrb,
    input  logic                                         wlast,

    input  logic                                         cancel_valid,
    input  logic [ID_WIDTH-1:0]                          cancel_id,

    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [IDX_W-1:0]                             out_index,
    output logic [ID_WIDTH-1:0]                          out_id,
    output logic [LEN_WIDTH-1:0]                         out_len,
    output logic [ADDR_WIDTH-1:0]                        out_addr,
    output logic [2:0]                                   out_size,
    output logic [1:0]                                   out_burst,
    output logic [USER_WIDTH-1:0]                        out_user,
    output logic                                         out_unluck,
    output logic [8*DATA_BYTES*(2**LEN_WIDTH)-1:0]       out_data,
    output logic [DATA_BYTES*(2**LEN_WIDTH)-1:0]         out_strb,

    output logic                                         err_wlast
);

    localparam int BEATS = 2 ** LEN_WIDTH;
    localparam int DW    = 8 * DATA_BYTES;
    localparam int CNT_W = $clog2(SLOT_AMOUNT + 1);

    // Per-slot header; declared here rather than in the package because its
    // field widths follow this module's parameters.
    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [LEN_WIDTH-1:0]  len;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [USER_WIDTH-1:0] user;
        logic                  unluck;
        logic [LEN_WIDTH-1:0]  cur_len;
        logic                  done;
    } burst_hdr_t;

    // Slot state
    burst_hdr_t             hdr        [SLOT_AMOUNT];
    logic [SLOT_AMOUNT-1:0] slot_valid;
    logic [DW-1:0]          data_mem   [SLOT_AMOUNT][BEATS];
    logic [DATA_BYTES-1:0]  strb_mem   [SLOT_AMOUNT][BEATS];

    logic [IDX_W-1:0]       head;
    logic [IDX_W-1:0]       tail;
    logic [IDX_W-1:0]       fill;
    logic [CNT_W-1:0]       count;

    logic                   full;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   out_hs;
    logic                   w_last_beat;
    logic [LEN_WIDTH-1:0]   fill_beat;

    // ------------------------------------------------------------------
    // Handshakes and flow control
    // ------------------------------------------------------------------
    assign full        = (count == CNT_W'(SLOT_AMOUNT));
    assign awready     = !full;
    // With the ring full, fill == tail can still mean "slots waiting for
    // data", so the fill slot's done flag breaks the tie.
    assign wready      = (fill != tail) || (full && !hdr[fill].done);
    assign out_valid   = slot_valid[head] && hdr[head].done;

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign out_hs      = out_valid && out_ready;

    assign fill_beat   = hdr[fill].cur_len;
    assign w_last_beat = (fill_beat == hdr[fill].len);

    // ------------------------------------------------------------------
    // Ring pointers
    // ------------------------------------------------------------------
    ring_ptr #(.DEPTH(SLOT_AMOUNT)) u_tail_ptr (
        .clk    (clk),
        .resetn (resetn),
        .inc    (aw_hs),
        .ptr    (tail)
    );

    ring_ptr #(.DEPTH(SLOT_AMOUNT)) u_fill_ptr (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_hs && w_last_beat),
        .ptr    (fill)
    );

    ring_ptr #(.DEPTH(SLOT_AMOUNT)) u_head_ptr (
        .clk    (clk),
        .resetn (resetn),
        .inc    (out_hs),
        .ptr    (head)
    );

    // Occupancy: +1 on AW, -1 on out, unchanged when both happen together
    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values; blocking '=' here would create order-dependent races.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            case ({aw_hs, out_hs})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Slot headers: cancel marking, beat progress, allocation, release.
    // tail, fill and head are distinct whenever their handshakes coincide,
    // so the writes below never target the same field of the same slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_valid <= '0;
            for (int i = 0; i < SLOT_AMOUNT; i++) begin
                hdr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOT_AMOUNT; i++) begin
                if (cancel_valid && slot_valid[i] && (hdr[i].id == cancel_id)) begin
                    hdr[i].unluck <= 1'b1;
                    hdr[i].user   <= USER_WIDTH'(UNLUCKY);
                end
            end

            if (w_hs) begin
                if (w_last_beat) begin
                    hdr[fill].done <= 1'b1;
                end else begin
                    hdr[fill].cur_len <= fill_beat + 1'b1;
                end
            end

            if (aw_hs) begin
                slot_valid[tail]  <= 1'b1;
                hdr[tail].id      <= awid;
                hdr[tail].len     <= awlen;
                hdr[tail].addr    <= awaddr;
                hdr[tail].size    <= awsize;
                hdr[tail].burst   <= awburst;
                hdr[tail].user    <= awuser;
                hdr[tail].unluck  <= 1'b0;
                hdr[tail].cur_len <= '0;
                hdr[tail].done    <= 1'b0;
            end

            // The burst handed out this cycle leaves as it was; any cancel
            // mark written to it above dies with the slot.
            if (out_hs) begin
                slot_valid[head] <= 1'b0;
                hdr[head].done   <= 1'b0;
            end
        end
    end

    // Burst payload storage: strobes cleared on allocation, beats written in order
    // NOTE: the payload arrays have no reset; a slot's contents are only
    // observable once its header says done, and strobes are cleared on AW.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            for (int b = 0; b < BEATS; b++) begin
                strb_mem[tail][b] <= '0;
            end
        end
        if (w_hs) begin
            data_mem[fill][fill_beat] <= wdata;
            strb_mem[fill][fill_beat] <= wstrb;
        end
    end

    // Output fields straight from the head slot, zero while nothing is offered
    // NOTE: every output gets a default first so no path through this block
    // leaves a value unassigned and infers a latch.
    always_comb begin
        out_id     = '0;
        out_len    = '0;
        out_addr   = '0;
        out_size   = '0;
        out_burst  = '0;
        out_user   = '0;
        out_unluck = 1'b0;
        out_data   = '0;
        out_strb   = '0;
        if (out_valid) begin
            out_id     = hdr[head].id;
            out_len    = hdr[head].len;
            out_addr   = hdr[head].addr;
            out_size   = hdr[head].size;
            out_burst  = hdr[head].burst;
            out_user   = hdr[head].user;
            out_unluck = hdr[head].unluck;
            for (int b = 0; b < BEATS; b++) begin
                out_data[beat_offset(b, DATA_BYTES) +: DW]  = data_mem[head][b];
                out_strb[b*DATA_BYTES +: DATA_BYTES]         = strb_mem[head][b];
            end
        end
    end

    assign out_index = head;

`ifdef BURST_SLOT_RING_WLAST_CHECK_EN
    logic err_wlast_q;

    // Sticky protocol flag: wlast must be high exactly on beat awlen
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_wlast_q <= 1'b0;
        end else if (w_hs && (wlast != w_last_beat)) begin
            err_wlast_q <= 1'b1;
        end
    end

    assign err_wlast = err_wlast_q;
`else
    logic wlast_unused;

    // wlast carries no information for the ring when checking is disabled
    assign wlast_unused = wlast;
    assign err_wlast    = 1'b0;
`endif

endmodule : burst_slot_ring

// File: tb/tb_burst_slot_ring.sv
// ---------------------------------------------------------------------------
// tb_burst_slot_ring
// Directed stimulus with a scoreboard: expected bursts are queued when their
// AW is issued; a monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_burst_slot_ring;
    import burst_slot_ring_pkg::*;

    localparam int SA = 6;
    localparam int DB = 16;
    localparam int DW = 8 * DB;
    localparam int BEATS = 8;

`ifdef BURST_SLOT_RING_WLAST_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic [2:0]             index;
        logic [3:0]             id;
        logic [2:0]             len;
        logic [31:0]            addr;
        logic [1:0]             user;
        logic                   unluck;
        logic [DW*BEATS-1:0]    data;
        logic [DW*BEATS-1:0]    mask;
        logic [DB*BEATS-1:0]    strb;
    } exp_t;

    logic                   clk;
    logic                   resetn;
    logic                   awvalid, awready;
    logic [3:0]             awid;
    logic [2:0]             awlen;
    logic [31:0]            awaddr;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic [1:0]             awuser;
    logic                   wvalid, wready;
    logic [DW-1:0]          wdata;
    logic [DB-1:0]          wstrb;
    logic                   wlast;
    logic                   cancel_valid;
    logic [3:0]             cancel_id;
    logic                   out_valid, out_ready;
    logic [2:0]             out_index;
    logic [3:0]             out_id;
    logic [2:0]             out_len;
    logic [31:0]            out_addr;
    logic [2:0]             out_size;
    logic [1:0]             out_burst;
    logic [1:0]             out_user;
    logic                   out_unluck;
    logic [DW*BEATS-1:0]    out_data;
    logic [DB*BEATS-1:0]    out_strb;
    logic                   err_wlast;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    burst_slot_ring dut (
        .clk          (clk),
        .resetn       (resetn),
        .awvalid      (awvalid),
        .awready      (awready),
        .awid         (awid),
        .awlen        (awlen),
        .awaddr       (awaddr),
        .awsize       (awsize),
        .awburst      (awburst),
        .awuser       (awuser),
        .wvalid       (wvalid),
        .wready       (wready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wlast        (wlast),
        .cancel_valid (cancel_valid),
        .cancel_id    (cancel_id),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_id       (out_id),
        .out_len      (out_len),
        .out_addr     (out_addr),
        .out_size     (out_size),
        .out_burst    (out_burst),
        .out_user     (out_user),
        .out_unluck   (out_unluck),
        .out_data     (out_data),
        .out_strb     (out_strb),
        .err_wlast    (err_wlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake timeout", name);
    endtask

    function automatic logic [DW-1:0] beat_val(input int tag, input int b);
        return {16'hDA7A, 16'(tag), 32'(b), 32'hC0DE_0000 + 32'(tag), 32'(b) ^ 32'h5A5A_5A5A};
    endfunction

    function automatic exp_t mk_exp(input int idx, input int id, input int len,
                                    input logic [31:0] addr, input logic [1:0] user,
                                    input logic unluck, input int tag, input logic [15:0] strb);
        exp_t e;
        e.index  = 3'(idx);
        e.id     = 4'(id);
        e.len    = 3'(len);
        e.addr   = addr;
        e.user   = user;
        e.unluck = unluck;
        e.data   = '0;
        e.mask   = '0;
        e.strb   = '0;
        for (int b = 0; b <= len; b++) begin
            e.data[b*DW +: DW] = beat_val(tag, b);
            e.mask[b*DW +: DW] = '1;
            e.strb[b*DB +: DB] = strb;
        end
        return e;
    endfunction

    // Scoreboard monitor: compares every output handshake against the queue
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got index %0d with no expected burst", out_index);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_index",  out_index,  mon_e.index);
                check("out_id",     out_id,     mon_e.id);
                check("out_len",    out_len,    mon_e.len);
                check("out_addr",   out_addr,   mon_e.addr);
                check("out_size",   out_size,   3'd4);
                check("out_burst",  out_burst,  2'b01);
                check("out_user",   out_user,   mon_e.user);
                check("out_unluck", out_unluck, mon_e.unluck);
                check("out_strb",   out_strb,   mon_e.strb);
                check("out_data",   out_data & mon_e.mask, mon_e.data);
            end
        end
    end

    task automatic send_aw(input int id, input int len, input logic [31:0] addr, input logic [1:0] user);
        bit ok = 0;
        @(posedge clk); #1;
        awvalid = 1'b1; awid = 4'(id); awlen = 3'(len); awaddr = addr; awuser = user;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        if (ok) @(posedge clk); else timeout("aw");
        #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] data, input logic [DB-1:0] strb, input logic last);
        bit ok = 0;
        @(posedge clk); #1;
        wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wready) begin ok = 1; break; end
        end
        if (ok) @(posedge clk); else timeout("w");
        #1 wvalid = 1'b0;
    endtask

    task automatic send_burst(input int tag, input int len, input logic [DB-1:0] strb);
        for (int b = 0; b <= len; b++) send_w(beat_val(tag, b), strb, b == len);
    endtask

    task automatic pop_out();
        bit ok = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (ok) @(posedge clk); else timeout("out");
        #1 out_ready = 1'b0;
    endtask

    task automatic aw_and_pop(input int id, input int len, input logic [31:0] addr, input logic [1:0] user);
        bit ok = 0;
        @(posedge clk); #1;
        awvalid = 1'b1; awid = 4'(id); awlen = 3'(len); awaddr = addr; awuser = user;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (awready && out_valid) begin ok = 1; break; end
        end
        if (ok) @(posedge clk); else timeout("aw_and_out");
        #1;
        awvalid   = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic cancel_pulse(input int id);
        @(posedge clk); #1;
        cancel_valid = 1'b1; cancel_id = 4'(id);
        @(posedge clk); #1;
        cancel_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b1;
        awvalid = 0; awid = 0; awlen = 0; awaddr = 0; awsize = 3'd4; awburst = 2'b01; awuser = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
        cancel_valid = 0; cancel_id = 0; out_ready = 0;

        // Reset state
        #2 resetn = 1'b0;
        #1;
        check("rst_awready",  awready,   1'b1);
        check("rst_wready",   wready,    1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_err_wlast", err_wlast, 1'b0);
        check("rst_out_data", out_data,  '0);
        check("rst_out_id",   out_id,    4'd0);
        check("rst_out_index", out_index, 3'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Basic two-beat burst at slot 0
        exp_q.push_back(mk_exp(0, 3, 1, 32'h1000, REGULAR, 1'b0, 1, 16'hFFFF));
        send_aw(3, 1, 32'h1000, REGULAR);
        send_w(beat_val(1, 0), 16'hFFFF, 1'b0);
        @(negedge clk) check("basic_valid_after_a", out_valid, 1'b0);
        send_w(beat_val(1, 1), 16'hFFFF, 1'b1);
        @(negedge clk) check("basic_valid_after_b", out_valid, 1'b1);
        pop_out();

        // WLAST asserted early on a three-beat burst (slot 1)
        exp_q.push_back(mk_exp(1, 2, 2, 32'h2000, DIVERT, 1'b0, 2, 16'hFFFF));
        send_aw(2, 2, 32'h2000, DIVERT);
        @(negedge clk) check("wlast_err_before", err_wlast, 1'b0);
        send_w(beat_val(2, 0), 16'hFFFF, 1'b1);
        @(negedge clk) check("wlast_err_beat0", err_wlast, EXP_ERR);
        send_w(beat_val(2, 1), 16'hFFFF, 1'b0);
        @(negedge clk) check("wlast_valid_beat1", out_valid, 1'b0);
        send_w(beat_val(2, 2), 16'hFFFF, 1'b1);
        @(negedge clk);
        check("wlast_valid_beat2", out_valid, 1'b1);
        check("wlast_err_sticky",  err_wlast, EXP_ERR);
        pop_out();

        // Reset mid-burst: two done slots and one half-filled slot are discarded
        send_aw(1, 0, 32'h5000, REGULAR);
        send_aw(2, 0, 32'h5010, REGULAR);
        send_aw(5, 1, 32'h5020, REGULAR);
        send_burst(40, 0, 16'hFFFF);
        send_burst(41, 0, 16'hFFFF);
        send_w(beat_val(42, 0), 16'hFFFF, 1'b0);
        @(negedge clk);
        check("midrst_valid_before", out_valid, 1'b1);
        check("midrst_wready_before", wready, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_wready",    wready,    1'b0);
        check("midrst_awready",   awready,   1'b1);
        check("midrst_err_wlast", err_wlast, 1'b0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Fill all six slots, drain one, seventh AW wraps to slot 0
        for (int i = 0; i < SA; i++) begin
            exp_q.push_back(mk_exp(i, i, 0, 32'h3000 + 32'(i * 16), REGULAR, 1'b0, 10 + i, 16'(16'h0101 << i)));
            send_aw(i, 0, 32'h3000 + 32'(i * 16), REGULAR);
        end
        @(negedge clk);
        check("full_awready", awready, 1'b0);
        check("full_wready",  wready,  1'b1);
        for (int i = 0; i < SA; i++) send_burst(10 + i, 0, 16'(16'h0101 << i));
        @(negedge clk);
        check("full_done_awready", awready, 1'b0);
        check("full_done_wready",  wready,  1'b0);
        pop_out();
        @(negedge clk) check("wrap_awready", awready, 1'b1);
        exp_q.push_back(mk_exp(0, 6, 0, 32'h3100, BLOCK, 1'b0, 16, 16'hFFFF));
        send_aw(6, 0, 32'h3100, BLOCK);
        send_burst(16, 0, 16'hFFFF);
        repeat (6) pop_out();

        // Count held at 3 across a simultaneous AW + out handshake
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk_exp(1 + i, 8 + i, 0, 32'h6000 + 32'(i * 16), REGULAR, 1'b0, 20 + i, 16'hFFFF));
            send_aw(8 + i, 0, 32'h6000 + 32'(i * 16), REGULAR);
            send_burst(20 + i, 0, 16'hFFFF);
        end
        exp_q.push_back(mk_exp(4, 11, 0, 32'h6030, REGULAR, 1'b0, 23, 16'hFFFF));
        aw_and_pop(11, 0, 32'h6030, REGULAR);
        exp_q.push_back(mk_exp(5, 12, 0, 32'h6040, REGULAR, 1'b0, 24, 16'hFFFF));
        send_aw(12, 0, 32'h6040, REGULAR);
        exp_q.push_back(mk_exp(0, 13, 0, 32'h6050, REGULAR, 1'b0, 25, 16'hFFFF));
        send_aw(13, 0, 32'h6050, REGULAR);
        @(negedge clk) check("simul_count5_awready", awready, 1'b1);
        exp_q.push_back(mk_exp(1, 14, 1, 32'h6060, REGULAR, 1'b0, 26, 16'hFFFF));
        send_aw(14, 1, 32'h6060, REGULAR);
        @(negedge clk) check("simul_count6_awready", awready, 1'b0);
        for (int i = 0; i < 3; i++) send_burst(23 + i, 0, 16'hFFFF);
        send_burst(26, 1, 16'hFFFF);
        repeat (6) pop_out();

        // Cancel id 3: two held bursts (one still filling) go UNLUCKY, id 4 untouched
        exp_q.push_back(mk_exp(2, 3, 0, 32'h4000, UNLUCKY, 1'b1, 30, 16'hFFFF));
        exp_q.push_back(mk_exp(3, 4, 0, 32'h4010, BLOCK,   1'b0, 31, 16'hFFFF));
        exp_q.push_back(mk_exp(4, 3, 1, 32'h4020, UNLUCKY, 1'b1, 32, 16'h00FF));
        send_aw(3, 0, 32'h4000, BLOCK);
        send_aw(4, 0, 32'h4010, BLOCK);
        send_aw(3, 1, 32'h4020, DIVERT);
        send_burst(30, 0, 16'hFFFF);
        send_burst(31, 0, 16'hFFFF);
        send_w(beat_val(32, 0), 16'h00FF, 1'b0);
        @(negedge clk);
        check("cancel_pre_unluck", out_unluck, 1'b0);
        check("cancel_pre_user",   out_user,   BLOCK);
        cancel_pulse(3);
        @(negedge clk);
        check("cancel_post_unluck", out_unluck, 1'b1);
        check("cancel_post_user",   out_user,   UNLUCKY);
        send_w(beat_val(32, 1), 16'h00FF, 1'b1);
        repeat (3) pop_out();

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_burst_slot_ring
